// File: rtl/pmic_status_reporter_pkg.sv
// ============================================================================
//  Module      : pmic_status_reporter_pkg
//  Description : Shared types and constants for the PMIC status reporter.
//                Frame length depends on STATUS_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package pmic_status_reporter_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_SEND      = 2'd1;
    localparam state_t ST_WAIT_DONE = 2'd2;

    localparam logic [2:0] BYTE_SYNC   = 3'd0;
    localparam logic [2:0] BYTE_RAIL   = 3'd1;
    localparam logic [2:0] BYTE_VOLT   = 3'd2;
    localparam logic [2:0] BYTE_CURR   = 3'd3;
    localparam logic [2:0] BYTE_STATUS = 3'd4;
    localparam logic [2:0] BYTE_CHK    = 3'd5;

`ifdef STATUS_CHECKSUM_EN
    localparam logic [2:0] FRAME_LEN = 3'd6;
`else
    localparam logic [2:0] FRAME_LEN = 3'd5;
`endif
    localparam logic [2:0] FRAME_LAST = FRAME_LEN - 3'd1;

    localparam logic [7:0] DEFAULT_SYNC_BYTE    = 8'hA5;
    localparam int         OSCILLATOR_FREQUENCY = 4160000;

    // Frame payload captured at frame start and held until the frame ends.
    typedef struct packed {
        logic [7:0] rail;
        logic [7:0] volt;
        logic [7:0] curr;
        logic [7:0] status;
    } snapshot_t;

`ifdef STATUS_CHECKSUM_EN
    function automatic logic [7:0] frame_checksum(input logic [7:0] sync_byte,
                                                  input snapshot_t snap);
        return sync_byte ^ snap.rail ^ snap.volt ^ snap.curr ^ snap.status;
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/pmic_fault_latch.sv
// ============================================================================
//  Module      : pmic_fault_latch
//  Description : Sticky fault bank; set dominates a simultaneous clear.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmic_fault_latch
    import pmic_status_reporter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_set,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_latched,
    output logic             o_rising
);

    logic [WIDTH-1:0] latch_q;
    logic [WIDTH-1:0] latch_d;

    always_comb begin
        latch_d = i_clear ? '0 : latch_q;
        latch_d = latch_d | i_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            latch_q <= '0;
        end else begin
            latch_q <= latch_d;
        end
    end

    assign o_latched = latch_q;
    // Only a 0->1 transition is news worth a report.
    assign o_rising  = |(i_set & ~latch_q);

endmodule

`default_nettype wire

// File: rtl/pmic_status_reporter.sv
// ============================================================================
//  Module      : pmic_status_reporter
//  Description : Latches rail faults and serialises status frames to uart_tx.
//                Optional checksum byte enabled by macro STATUS_CHECKSUM_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmic_status_reporter
    import pmic_status_reporter_pkg::*;
#(
    parameter int         NUM_RAILS     = 4,
    parameter int         REPORT_PERIOD = OSCILLATOR_FREQUENCY,
    parameter int         TX_TIMEOUT    = 20000,
    parameter logic [7:0] SYNC_BYTE     = DEFAULT_SYNC_BYTE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_RAILS-1:0] i_railGood,
    input  logic [NUM_RAILS-1:0] i_voltageFault,
    input  logic [NUM_RAILS-1:0] i_currentFault,
    input  logic [2:0]           i_stageGood,
    input  logic                 i_clearLatched,
    input  logic                 i_txBusy,
    input  logic                 i_txDone,
    output logic                 o_txBegin,
    output logic [7:0]           o_txData,
    output logic                 o_reportActive,
    output logic                 o_latchedFault,
    output logic                 o_txError
);

    localparam int PERIOD_W  = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
    localparam int TIMEOUT_W = $clog2(TX_TIMEOUT + 1);

    state_t                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [4:0]             seq_q, seq_d;
    logic [2:0]             idx_q, idx_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
    snapshot_t              snap_q, snap_d;
    logic                   tx_begin_q, tx_begin_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_error_q, tx_error_d;
    logic [NUM_RAILS-1:0]   rail_prev_q, rail_prev_d;
    logic [2:0]             stage_prev_q, stage_prev_d;
    logic                   prev_valid_q, prev_valid_d;

    logic [NUM_RAILS-1:0]   volt_latched;
    logic [NUM_RAILS-1:0]   curr_latched;
    logic                   volt_rising;
    logic                   curr_rising;
    logic                   frame_start;
    logic                   byte_fire;
    logic                   byte_done;
    logic                   frame_done;
    logic                   tmo_hit;
    logic                   period_hit;
    logic                   input_change;
    logic [7:0]             frame_byte;

    pmic_fault_latch #(.WIDTH(NUM_RAILS)) u_volt_latch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_set     (i_voltageFault),
        .i_clear   (i_clearLatched),
        .o_latched (volt_latched),
        .o_rising  (volt_rising)
    );

    pmic_fault_latch #(.WIDTH(NUM_RAILS)) u_curr_latch (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_set     (i_currentFault),
        .i_clear   (i_clearLatched),
        .o_latched (curr_latched),
        .o_rising  (curr_rising)
    );

    assign frame_start = (state_q == ST_IDLE) && pending_q;
    assign byte_fire   = (state_q == ST_SEND) && !i_txBusy;
    assign byte_done   = (state_q == ST_WAIT_DONE) && i_txDone;
    assign frame_done  = byte_done && (idx_q == FRAME_LAST);
    assign tmo_hit     = (state_q == ST_WAIT_DONE) && !i_txDone &&
                         (tmo_q == TIMEOUT_W'(TX_TIMEOUT - 1));
    assign period_hit  = (period_q == PERIOD_W'(REPORT_PERIOD - 1));
    // The first cycle after reset has no valid history; the boot frame covers it.
    assign input_change = prev_valid_q &&
                          ((i_railGood != rail_prev_q) || (i_stageGood != stage_prev_q));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!i_txBusy) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_txDone) begin
                    state_d = (idx_q == FRAME_LAST) ? ST_IDLE : ST_SEND;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            BYTE_SYNC:   frame_byte = SYNC_BYTE;
            BYTE_RAIL:   frame_byte = snap_q.rail;
            BYTE_VOLT:   frame_byte = snap_q.volt;
            BYTE_CURR:   frame_byte = snap_q.curr;
            BYTE_STATUS: frame_byte = snap_q.status;
`ifdef STATUS_CHECKSUM_EN
            BYTE_CHK:    frame_byte = frame_checksum(SYNC_BYTE, snap_q);
`endif
            default:     frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        pending_d    = pending_q;
        seq_d        = seq_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        tx_begin_d   = byte_fire;
        tx_data_d    = byte_fire ? frame_byte : tx_data_q;
        tx_error_d   = tx_error_q;
        tmo_d        = (state_q == ST_WAIT_DONE) ? tmo_q + TIMEOUT_W'(1) : '0;
        rail_prev_d  = i_railGood;
        stage_prev_d = i_stageGood;
        prev_valid_d = 1'b1;

        if (frame_start || period_hit) begin
            period_d = '0;
        end else begin
            period_d = period_q + PERIOD_W'(1);
        end

        if (frame_start) begin
            pending_d     = 1'b0;
            idx_d         = BYTE_SYNC;
            snap_d.rail   = 8'(i_railGood);
            snap_d.volt   = 8'(volt_latched);
            snap_d.curr   = 8'(curr_latched);
            snap_d.status = {i_stageGood, seq_q};
        end

        if (byte_done && !frame_done) begin
            idx_d = idx_q + 3'd1;
        end

        if (frame_done) begin
            seq_d      = seq_q + 5'd1;
            tx_error_d = 1'b0;
        end

        if (tmo_hit) begin
            tx_error_d = 1'b1;
        end

        // New events win over the clear so nothing seen at frame start is lost.
        if (period_hit || input_change || volt_rising || curr_rising || tmo_hit) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q    <= 1'b1;
            seq_q        <= '0;
            idx_q        <= '0;
            period_q     <= '0;
            tmo_q        <= '0;
            snap_q       <= '0;
            tx_begin_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_error_q   <= 1'b0;
            rail_prev_q  <= '0;
            stage_prev_q <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            period_q     <= period_d;
            tmo_q        <= tmo_d;
            snap_q       <= snap_d;
            tx_begin_q   <= tx_begin_d;
            tx_data_q    <= tx_data_d;
            tx_error_q   <= tx_error_d;
            rail_prev_q  <= rail_prev_d;
            stage_prev_q <= stage_prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign o_txBegin      = tx_begin_q;
    assign o_txData       = tx_data_q;
    assign o_reportActive = (state_q != ST_IDLE);
    assign o_latchedFault = |{volt_latched, curr_latched};
    assign o_txError      = tx_error_q;

endmodule

`default_nettype wire

// File: tb/tb_pmic_status_reporter.sv
// ============================================================================
//  Module      : tb_pmic_status_reporter
//  Description : Scoreboard bench for pmic_status_reporter with a uart_tx model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pmic_status_reporter;

    localparam int NR        = 4;
    localparam int RP        = 1000;
    localparam int TO        = 200;
    localparam int BUSY_CLKS = 50;
`ifdef STATUS_CHECKSUM_EN
    localparam int FL = 6;
`else
    localparam int FL = 5;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] rail_good = '0;
    logic [NR-1:0] volt_fault = '0;
    logic [NR-1:0] curr_fault = '0;
    logic [2:0]    stage_good = '0;
    logic          clear_latched = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_begin;
    logic [7:0]    tx_data;
    logic          report_active;
    logic          latched_fault;
    logic          tx_error;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         bytes_seen = 0;
    int         sof_cyc = 0;
    int         prev_sof_cyc = 0;
    int         drop_req = 0;
    logic [8:0] exp_q[$];

    pmic_status_reporter #(
        .NUM_RAILS     (NR),
        .REPORT_PERIOD (RP),
        .TX_TIMEOUT    (TO)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_railGood     (rail_good),
        .i_voltageFault (volt_fault),
        .i_currentFault (curr_fault),
        .i_stageGood    (stage_good),
        .i_clearLatched (clear_latched),
        .i_txBusy       (tx_busy),
        .i_txDone       (tx_done),
        .o_txBegin      (tx_begin),
        .o_txData       (tx_data),
        .o_reportActive (report_active),
        .o_latchedFault (latched_fault),
        .o_txError      (tx_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] rail, input logic [7:0] v, input logic [7:0] c,
                              input logic [2:0] stg, input logic [4:0] sq);
        logic [7:0] b [0:5];
        b[0] = 8'hA5;
        b[1] = rail;
        b[2] = v;
        b[3] = c;
        b[4] = {stg, sq};
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        for (int i = 0; i < FL; i++) exp_q.push_back({(i == 0), b[i]});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && !report_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: drain timeout, %0d bytes outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_bytes(input string name, input int target, input int budget);
        int n = 0;
        while (bytes_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: byte timeout, saw %0d, expected %0d", name, bytes_seen, target);
        end
    endtask

    // uart_tx model: busy for BUSY_CLKS after a start, then a one-cycle done pulse
    initial begin
        int busy_cnt = 0;
        int drops_done = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_begin) begin
                check("begin_while_idle", {31'd0, tx_busy}, 32'd0);
                tx_busy  = 1'b1;
                busy_cnt = BUSY_CLKS;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    tx_busy = 1'b0;
                    if (drops_done < drop_req) drops_done++;
                    else tx_done = 1'b1;
                end
            end
        end
    end

    // Monitor: every start pulse is scored against the expected byte stream.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (tx_begin) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %02h, expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, e[7:0]});
                    if (e[8]) begin
                        prev_sof_cyc = sof_cyc;
                        sof_cyc      = cyc;
                    end
                end
                bytes_seen++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] exp_seq;
        int         iv;
        int         base;

        rail_good  = 4'hF;
        stage_good = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_begin",  {31'd0, tx_begin},      32'd0);
        check("rst_data",   {24'd0, tx_data},       32'd0);
        check("rst_active", {31'd0, report_active}, 32'd0);
        check("rst_latch",  {31'd0, latched_fault}, 32'd0);
        check("rst_error",  {31'd0, tx_error},      32'd0);

        // 1: boot frame
        push_frame(8'h0F, 8'h00, 8'h00, 3'b111, 5'd0);
        exp_seq = 5'd1;
        rst_n = 1'b1;
        wait_drain("boot_frame", 2000);

        // 2: periodic frames through a sequence wrap
        for (int k = 0; k < 32; k++) begin
            push_frame(8'h0F, 8'h00, 8'h00, 3'b111, exp_seq);
            exp_seq = exp_seq + 5'd1;
            wait_drain("periodic_frame", 2000);
            iv = sof_cyc - prev_sof_cyc;
            vectors++;
            if (iv < RP - 2 || iv > RP + 3) begin
                miscompares++;
                $display("FAIL period: got %0d clocks, expected about %0d", iv, RP);
            end
        end

        // 3: fault pulse mid-frame, then clear
        base = bytes_seen;
        push_frame(8'h0F, 8'h00, 8'h00, 3'b111, exp_seq);
        exp_seq = exp_seq + 5'd1;
        wait_bytes("mid_frame", base + 2, 2000);
        @(posedge clk); #1;
        volt_fault = 4'b0100;
        @(posedge clk); #1;
        volt_fault = 4'b0000;
        check("latched_after_pulse", {31'd0, latched_fault}, 32'd1);
        push_frame(8'h0F, 8'h04, 8'h00, 3'b111, exp_seq);
        exp_seq = exp_seq + 5'd1;
        wait_drain("fault_frame", 3000);
        @(posedge clk); #1;
        clear_latched = 1'b1;
        @(posedge clk); #1;
        clear_latched = 1'b0;
        check("latched_after_clear", {31'd0, latched_fault}, 32'd0);
        push_frame(8'h0F, 8'h00, 8'h00, 3'b111, exp_seq);
        exp_seq = exp_seq + 5'd1;
        wait_drain("cleared_frame", 2000);

        // 4: simultaneous set and clear, set wins
        @(posedge clk); #1;
        volt_fault    = 4'b0010;
        clear_latched = 1'b1;
        @(posedge clk); #1;
        volt_fault    = 4'b0000;
        clear_latched = 1'b0;
        check("set_wins", {31'd0, latched_fault}, 32'd1);
        push_frame(8'h0F, 8'h02, 8'h00, 3'b111, exp_seq);
        exp_seq = exp_seq + 5'd1;
        wait_drain("set_wins_frame", 2000);

        // 5: missing done pulse -> abort and retry with same sequence number
        drop_req = 1;
        exp_q.push_back({1'b1, 8'hA5});
        push_frame(8'h0F, 8'h02, 8'h00, 3'b111, exp_seq);
        exp_seq = exp_seq + 5'd1;
        begin
            int n = 0;
            while (!tx_error && n < 3000) begin
                @(negedge clk);
                n++;
            end
        end
        check("tx_error_set", {31'd0, tx_error}, 32'd1);
        wait_drain("retry_frame", 3000);
        check("tx_error_clear", {31'd0, tx_error}, 32'd0);

        // 6: reset during byte 3, released while uart still busy
        base = bytes_seen;
        push_frame(8'h0F, 8'h02, 8'h00, 3'b111, exp_seq);
        wait_bytes("byte3", base + 4, 3000);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_begin",  {31'd0, tx_begin},      32'd0);
        check("midrst_data",   {24'd0, tx_data},       32'd0);
        check("midrst_active", {31'd0, report_active}, 32'd0);
        check("midrst_latch",  {31'd0, latched_fault}, 32'd0);
        check("midrst_error",  {31'd0, tx_error},      32'd0);
        exp_q.delete();
        push_frame(8'h0F, 8'h00, 8'h00, 3'b111, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain("post_reset_boot", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
